// File: rtl/beat_pkg.sv
// Shared types and default tuning constants for the beat detector.
package beat_pkg;

   typedef enum logic [1:0] {
      SEARCH     = 2'd0,
      ABOVE      = 2'd1,
      REFRACTORY = 2'd2
   } state_t;

   localparam int DEF_SAMPLE_W = 10;
   localparam int DEF_PERIOD_W = 16;
   localparam int DEF_HYST     = 16;
   localparam int DEF_REFRACT  = 50;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority) and enable; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/beat_detector.sv
// Threshold/hysteresis beat detector on a strobed sample stream; reports peak,
// beat-to-beat period in valid samples and a no-beat timeout.
module beat_detector
   import beat_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int HYST     = DEF_HYST,
   parameter int REFRACT  = DEF_REFRACT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [SAMPLE_W-1:0] thresh,
   output logic                beat,
   output logic [SAMPLE_W-1:0] peak,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                timeout
);

   localparam int RW = $clog2(REFRACT + 1);
   localparam logic [RW-1:0]       REFR_LAST = RW'(REFRACT - 1);
   localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
   localparam logic [PERIOD_W-1:0] CNT_PRE   = CNT_MAX - PERIOD_W'(1);

   state_t              state, state_nx;
   logic [SAMPLE_W-1:0] run_max;
   logic [SAMPLE_W:0]   lo_diff;
   logic [SAMPLE_W-1:0] lo;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] cnt_inc;
   logic [RW-1:0]       refr_cnt;
   logic                prior;
   logic                beat_evt;
   logic                sat_hit;
   logic                max_ld;
   logic                refr_en;

   assign lo_diff = {1'b0, thresh} - (SAMPLE_W + 1)'(HYST);
   assign lo      = lo_diff[SAMPLE_W] ? '0 : lo_diff[SAMPLE_W-1:0];
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + PERIOD_W'(1);
   assign refr_en = sample_valid && (state == REFRACTORY);

   sat_counter #(.W(PERIOD_W)) u_interval (
      .clk    (clk),
      .reset  (reset),
      .clear  (beat_evt),
      .enable (sample_valid),
      .count  (cnt)
   );

   sat_counter #(.W(RW)) u_refract (
      .clk    (clk),
      .reset  (reset),
      .clear  (beat_evt),
      .enable (refr_en),
      .count  (refr_cnt)
   );

   always_comb begin
      state_nx = state;
      beat_evt = 1'b0;
      max_ld   = 1'b0;
      sat_hit  = 1'b0;
      if (sample_valid) begin
         case (state)
            SEARCH: begin
               if (sample >= thresh) begin
                  state_nx = ABOVE;
                  max_ld   = 1'b1;
               end
            end
            ABOVE: begin
               if (sample < lo) begin
                  beat_evt = 1'b1;
                  state_nx = REFRACTORY;
               end else if (sample > run_max) begin
                  max_ld = 1'b1;
               end
            end
            REFRACTORY: begin
               if (refr_cnt == REFR_LAST)
                  state_nx = SEARCH;
            end
            default: state_nx = SEARCH;
         endcase
         // Timeout fires only on the sample that takes cnt into saturation,
         // so a later pulse can still be detected and clear it.
         if (!beat_evt && (cnt == CNT_PRE)) begin
            sat_hit  = 1'b1;
            state_nx = SEARCH;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= SEARCH;
         run_max      <= '0;
         beat         <= 1'b0;
         peak         <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         prior        <= 1'b0;
      end else begin
         state <= state_nx;
         beat  <= beat_evt;
         if (max_ld)
            run_max <= sample;
         if (beat_evt) begin
            peak    <= run_max;
            timeout <= 1'b0;
            prior   <= 1'b1;
            if (prior) begin
               period       <= cnt_inc;
               period_valid <= 1'b1;
            end
         end else if (sat_hit) begin
            timeout      <= 1'b1;
            period_valid <= 1'b0;
            prior        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_beat_detector.sv
// Directed + randomized bench for beat_detector against an index-based reference model.
module tb_beat_detector;

   localparam int SW      = 10;
   localparam int PW      = 8;
   localparam int HYST    = 16;
   localparam int REFRACT = 50;
   localparam int PMAX    = 255;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sample_valid = 1'b0;
   logic [SW-1:0] sample = '0;
   logic [SW-1:0] thresh = 10'd500;
   logic          beat;
   logic [SW-1:0] peak;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          timeout;

   int n_chk = 0;
   int n_bad = 0;

   // reference model state: positions are valid-sample indices since reset
   int n, ref_n, last_beat, pmax;
   bit have_beat, in_pulse, prior;
   int m_beat, m_peak, m_period, m_pv, m_to;

   beat_detector #(.SAMPLE_W(SW), .PERIOD_W(PW), .HYST(HYST), .REFRACT(REFRACT)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .thresh       (thresh),
      .beat         (beat),
      .peak         (peak),
      .period       (period),
      .period_valid (period_valid),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      n = 0; ref_n = 0; last_beat = 0; pmax = 0;
      have_beat = 0; in_pulse = 0; prior = 0;
      m_beat = 0; m_peak = 0; m_period = 0; m_pv = 0; m_to = 0;
   endtask

   task automatic model(input int s);
      int thr, lo;
      bit hit;
      thr = int'(thresh);
      lo  = (thr >= HYST) ? thr - HYST : 0;
      hit = 0;
      n++;
      if (!(have_beat && (n - last_beat <= REFRACT))) begin
         if (!in_pulse) begin
            if (s >= thr) begin
               in_pulse = 1;
               pmax = s;
            end
         end else if (s < lo) begin
            hit = 1;
         end else if (s > pmax) begin
            pmax = s;
         end
      end
      m_beat = hit;
      if (hit) begin
         m_peak = pmax;
         in_pulse = 0;
         if (prior) begin
            m_period = (n - ref_n > PMAX) ? PMAX : n - ref_n;
            m_pv = 1;
         end
         prior = 1; m_to = 0; ref_n = n; last_beat = n; have_beat = 1;
      end else if (n - ref_n == PMAX) begin
         m_to = 1; m_pv = 0; prior = 0; in_pulse = 0; have_beat = 0;
      end
   endtask

   task automatic check_all();
      chk("beat", beat, m_beat);
      chk("peak", peak, m_peak);
      chk("period", period, m_period);
      chk("period_valid", period_valid, m_pv);
      chk("timeout", timeout, m_to);
   endtask

   // one clock: optionally present a sample, then compare on the falling edge
   task automatic step(input bit v, input int s);
      sample_valid = v;
      sample = SW'(s);
      @(posedge clk);
      if (v) model(s); else m_beat = 0;
      #1 sample_valid = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int s, input int gap);
      step(1'b1, s);
      for (int g = 0; g < gap; g++) step(1'b0, 0);
   endtask

   task automatic zeros(input int cnt);
      for (int z = 0; z < cnt; z++) run(0, 0);
   endtask

   // asynchronous reset landing between clock edges
   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, 0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      reset = 1'b0;
      step(1'b0, 0);

      // single pulse with uneven strobe spacing
      thresh = 10'd500;
      run(0, 1); run(520, 0); run(600, 2); run(550, 0); run(480, 0);
      chk("beat_first", beat, 1);
      chk("peak_first", peak, 600);
      chk("pv_first", period_valid, 0);
      step(1'b0, 0);
      chk("beat_width", beat, 0);

      // second pulse, falling crossing 100 samples later
      zeros(96);
      run(520, 0); run(600, 0); run(550, 0); run(480, 0);
      chk("period_100", period, 100);
      chk("pv_second", period_valid, 1);

      // ripple inside hysteresis band
      zeros(60);
      run(520, 0); run(510, 0); run(490, 0);
      chk("ripple_no_beat", beat, 0);
      run(505, 0); run(300, 0);
      chk("ripple_end_beat", beat, 1);
      chk("ripple_peak", peak, 520);

      // crossing during refractory is ignored
      zeros(19);
      run(520, 0); run(600, 0); run(300, 0);
      chk("refract_no_beat", beat, 0);
      chk("refract_period", period, 65);
      zeros(40);

      // equality edges: ==thresh is above, ==lo is not below
      run(500, 0); run(484, 0);
      chk("lo_equal_no_beat", beat, 0);
      run(483, 0);
      chk("lo_minus1_beat", beat, 1);
      chk("eq_peak", peak, 500);

      // timeout then first beat after it
      zeros(270);
      chk("timeout_set", timeout, 1);
      chk("timeout_pv", period_valid, 0);
      run(520, 0); run(480, 0);
      chk("timeout_beat", beat, 1);
      chk("timeout_clear", timeout, 0);
      chk("timeout_pv_after", period_valid, 0);

      // threshold below hysteresis: only a timeout exits the pulse
      thresh = 10'd10;
      zeros(60);
      run(20, 0);
      zeros(260);
      chk("lo0_timeout", timeout, 1);

      // reset while above threshold, sparse strobes
      thresh = 10'd500;
      run(520, 3);
      async_reset();
      chk("rst_peak", peak, 0);
      run(0, 3); run(0, 3);
      chk("rst_no_beat", beat, 0);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         if (k % 250 == 0) begin
            case ($urandom_range(0, 3))
               0: thresh = 10'd500;
               1: thresh = 10'd5;
               2: thresh = 10'd300;
               default: thresh = 10'd900;
            endcase
         end
         if ($urandom_range(0, 199) == 0) begin
            @(negedge clk);
            async_reset();
         end
         run(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
